input_event_scheduler: RTL and testbench
========================================

Name: input_event_scheduler

Overview:
- Turns the level-based button vector from the gamepad decoder into a stream of discrete key events for the game logic.
- Detects new presses, generates typematic auto-repeat for selected buttons, and arbitrates round-robin among pending events.
- Presents one event at a time on a valid/ready handshake.
- Sits between the gamepad decoder and the game FSM, so the FSM never has to do its own edge or repeat handling.

Parameters:
- N, 24, width of the button vector (max 32).
- TICK_DIV, 25000, clk cycles per repeat tick (1 ms at 25 MHz).
- DELAY, 400, ticks from press to first repeat; must be ≥1.
- RATE, 100, ticks between subsequent repeats; must be ≥1.
- REPEAT_MASK, 24'h0F0000, bit i set means button i auto-repeats.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- buttons  input  N  current button levels from the gamepad decoder; 1 = pressed
- flush  input  1  discard all pending and held events
- event_ready  input  1  consumer accepts the current event
- event_valid  output  1  event available
- event_code  output  5  index of the button for this event
- overrun  output  1  one-cycle pulse when an event merges into an already-pending bit

Behaviour:
- Reset: prev, pending, ptr, event_valid, event_code, overrun all 0; repeat FSM IDLE; prescaler and timer at 0.
  - A button held through reset release produces one press event.
- Prescaler counts 0..TICK_DIV-1; tick is high in the cycle the count is TICK_DIV-1, then it wraps to 0.
- Edge detect:
  - prev <= buttons every cycle.
  - press = buttons & ~prev.
  - Each press bit sets pending[i] at the next edge.
- Repeat FSM, with states IDLE, DELAY and REPEAT, tracked index rk and 16-bit timer:
  - New repeatable press (press & REPEAT_MASK nonzero), from any state: rk <= lowest such index, timer <= DELAY, state DELAY. This wins over any fire in the same cycle.
  - DELAY or REPEAT with buttons[rk]==0: go to IDLE, with no fire this cycle.
  - DELAY or REPEAT on tick:
    - If timer==1: fire (set pending[rk]), timer <= RATE, state REPEAT.
    - Otherwise timer <= timer-1.
  - Releasing a non-tracked button does not affect the FSM.
- Pending set sources: press OR fire.
  - If a set lands on a bit that is already pending and not cleared this cycle, assert overrun for one cycle; the bit stays 1 (events merge).
- Output stage: a registered holding slot.
  - When event_valid==0, or event_valid && event_ready, the slot loads the next event. The next event is the first set pending bit searching upward from ptr, wrapping at N-1 to 0.
  - On load: event_valid <= 1, event_code <= j, pending[j] cleared, ptr <= (j+1) mod N.
  - If nothing is pending: event_valid <= 0.
  - Set and clear of the same bit in one cycle: the set wins.
- event_code is stable while event_valid && !event_ready.
- Latency: buttons bit rises at edge t; pending set at t+1; event_valid at t+2 if the slot is empty. Sustained throughput is 1 event/cycle with ready held high.
- flush (synchronous):
  - pending <= 0, event_valid <= 0, FSM to IDLE.
  - prev still updates, so held buttons do not re-fire.
  - Presses in the flush cycle are discarded.
  - rst has priority over flush.
- event_code bits above log2(N) are 0.

Test Plan:
- (TICK_DIV=4, DELAY=3, RATE=2) Set buttons[3]=1 (not repeatable) for 100 cycles with ready=1 -> exactly one event, code 3, event_valid high at edge 2 after the press.
- Hold buttons[16] (repeatable) with ready=1 -> events with code 16 at the press, about 12 cycles later, then every 8 cycles. Release -> no further events.
- Press bits 2, 5 and 9 in the same cycle with ready=0 for 10 cycles, then ready=1 -> codes 2, 5, 9 on consecutive cycles. Code stays at 2 throughout the stall.
- With ptr=6 after accepting code 5, press bits 2 and 7 together -> order 7 then 2 (wrap check).
- Press bit 4, release, and press again while pending[4] is still set (ready=0) -> one overrun pulse; only one code-4 event is delivered.
- Hold bit 17, then assert flush for 1 cycle mid-DELAY -> event_valid low the next cycle and no repeat of 17. Re-pressing 17 after release -> a new event.

Source files
------------

// File: rtl/input_event_scheduler.sv
// -----------------------------------------------------------------------------
// input_event_scheduler
//
// Converts the level-based button vector from the gamepad decoder into a
// stream of discrete key events. Each new press becomes one pending event.
// Buttons in REPEAT_MASK also generate typematic auto-repeat: the first repeat
// comes DELAY ticks after the press and later ones every RATE ticks. Pending
// events are taken round-robin into a registered output slot that is read
// through a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   buttons      current button levels, 1 = pressed
//   flush        discard all pending and held events (synchronous)
//   event_ready  consumer accepts the current event
//   event_valid  an event is presented on event_code
//   event_code   index of the button for the presented event
//   overrun      one-cycle pulse when an event merges into a pending bit
// -----------------------------------------------------------------------------
module input_event_scheduler #(
  parameter int unsigned    N           = 24,
  parameter int unsigned    TICK_DIV    = 25000,
  parameter int unsigned    DELAY       = 400,
  parameter int unsigned    RATE        = 100,
  parameter logic [N-1:0]   REPEAT_MASK = 24'h0F0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] buttons,
  input  logic         flush,
  input  logic         event_ready,
  output logic         event_valid,
  output logic [4:0]   event_code,
  output logic         overrun
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rep_state_e;

  logic [CW-1:0] presc_q;
  logic          tick;

  logic [N-1:0]  prev_q;
  logic [N-1:0]  pending_q;
  logic [N-1:0]  pending_d;
  logic [N-1:0]  press;
  logic [N-1:0]  rep_press;
  logic [N-1:0]  set_vec;
  logic [N-1:0]  clr_vec;

  rep_state_e    state_q;
  logic [4:0]    rk_q;
  logic [4:0]    rk_new;
  logic [15:0]   timer_q;
  logic          tracking;
  logic          fire;

  logic [4:0]    ptr_q;
  logic [4:0]    ptr_d;
  logic [4:0]    sel;
  logic [5:0]    idx;
  logic          found;
  logic          load;
  logic          merge;

  logic          valid_q;
  logic [4:0]    code_q;
  logic          overrun_q;

  // Repeat-tick prescaler: tick is high while the count sits at TICK_DIV-1.
  assign tick = (presc_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= so every register in this
    // design samples the pre-edge value of every other register.
    if (rst)       presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 1'b1;
  end

  assign press     = buttons & ~prev_q;
  assign rep_press = press & REPEAT_MASK;

  // Lowest-index repeatable press becomes the tracked button.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it holding its old value (which would infer a latch).
    rk_new = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rep_press[i]) rk_new = 5'(i);
    end
  end

  assign tracking = (state_q != S_IDLE);

  // A new repeatable press or a release of the tracked key suppresses firing.
  assign fire = !flush && (rep_press == '0) && tracking && buttons[rk_q] &&
                tick && (timer_q == 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rk_q    <= '0;
      timer_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else if (rep_press != '0) begin
      rk_q    <= rk_new;
      timer_q <= 16'(DELAY);
      state_q <= S_DELAY;
    end else if (tracking) begin
      if (!buttons[rk_q]) begin
        state_q <= S_IDLE;
      end else if (tick) begin
        if (timer_q == 16'd1) begin
          timer_q <= 16'(RATE);
          state_q <= S_REPEAT;
        end else begin
          timer_q <= timer_q - 16'd1;
        end
      end
    end
  end

  // Round-robin search: first pending bit at or above ptr, wrapping at N-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + 6'(k);
      if (idx >= 6'(N)) idx = idx - 6'(N);
      if (!found && pending_q[idx[4:0]]) begin
        found = 1'b1;
        sel   = idx[4:0];
      end
    end
  end

  // The slot reloads whenever it is empty or its event is being accepted.
  assign load = !valid_q || event_ready;

  always_comb begin
    clr_vec = '0;
    ptr_d   = ptr_q;
    if (load && found) begin
      clr_vec[sel] = 1'b1;
      ptr_d        = (sel == 5'(N - 1)) ? 5'd0 : sel + 5'd1;
    end
  end

  always_comb begin
    set_vec = press;
    if (fire) set_vec[rk_q] = 1'b1;
  end

  // Set wins over clear; a set onto a bit that stays pending is a merge.
  assign pending_d = (pending_q & ~clr_vec) | set_vec;
  assign merge     = |(set_vec & pending_q & ~clr_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      pending_q <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      // prev tracks buttons even during flush so held keys do not re-fire.
      prev_q <= buttons;
      if (flush) begin
        pending_q <= '0;
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        pending_q <= pending_d;
        ptr_q     <= ptr_d;
        overrun_q <= merge;
        if (load) begin
          valid_q <= found;
          if (found) code_q <= sel;
        end
      end
    end
  end

  assign event_valid = valid_q;
  assign event_code  = code_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_input_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_input_event_scheduler
//
// Scenario tasks plus a randomized run for input_event_scheduler (N=24,
// TICK_DIV=4, DELAY=3, RATE=2). A behavioural reference model tracks the
// expected outputs: repeats are derived by counting ticks since the press,
// arbitration by a modulo scan of the pending set.
// -----------------------------------------------------------------------------
module tb_input_event_scheduler;

  localparam int          N        = 24;
  localparam int          TICK_DIV = 4;
  localparam int          DELAY    = 3;
  localparam int          RATE     = 2;
  localparam logic [N-1:0] RMASK   = 24'h0F0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] buttons = '0;
  logic         flush = 1'b0;
  logic         event_ready = 1'b0;
  logic         event_valid;
  logic [4:0]   event_code;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  input_event_scheduler #(
    .N(N), .TICK_DIV(TICK_DIV), .DELAY(DELAY), .RATE(RATE), .REPEAT_MASK(RMASK)
  ) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .flush(flush),
    .event_ready(event_ready), .event_valid(event_valid),
    .event_code(event_code), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [N-1:0] m_prev, m_pend;
  int           m_ptr, m_code, m_rk, m_ticks, m_cyc;
  bit           m_valid, m_over, m_trk;

  // Observed deliveries (code and the cycle in which valid&&ready was seen).
  int obs_code[$];
  int obs_cyc[$];
  int cyc_n   = 0;
  int ovr_cnt = 0;

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    logic [N-1:0] prs, rep, setv, clrv;
    bit tick, fire, got;
    int j, t;
    if (rst) begin
      m_prev = '0; m_pend = '0; m_ptr = 0; m_code = 0; m_valid = 0;
      m_over = 0; m_trk = 0; m_rk = 0; m_ticks = 0; m_cyc = 0;
      return;
    end
    tick  = (m_cyc % TICK_DIV) == TICK_DIV - 1;
    m_cyc = m_cyc + 1;
    prs   = buttons & ~m_prev;
    m_prev = buttons;
    if (flush) begin
      m_pend = '0; m_valid = 0; m_over = 0; m_trk = 0;
      return;
    end
    fire = 0;
    rep  = prs & RMASK;
    if (rep != '0) begin
      got = 0;
      for (int i = 0; i < N; i++) if (rep[i] && !got) begin m_rk = i; got = 1; end
      m_trk = 1; m_ticks = 0;
    end else if (m_trk && !buttons[m_rk]) begin
      m_trk = 0;
    end else if (m_trk && tick) begin
      m_ticks = m_ticks + 1;
      if (m_ticks >= DELAY && (m_ticks - DELAY) % RATE == 0) fire = 1;
    end
    setv = prs;
    if (fire) setv[m_rk] = 1'b1;
    clrv = '0;
    if (!m_valid || event_ready) begin
      got = 0; j = 0;
      for (int k = 0; k < N; k++) begin
        t = (m_ptr + k) % N;
        if (!got && m_pend[t]) begin got = 1; j = t; end
      end
      if (got) begin
        m_valid = 1; m_code = j; clrv[j] = 1'b1; m_ptr = (j + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    m_over = |(setv & m_pend & ~clrv);
    m_pend = (m_pend & ~clrv) | setv;
  endtask

  // One clock cycle: log a handshake, step the model, sample #1 after the edge.
  task automatic cyc();
    if (event_valid === 1'b1 && event_ready === 1'b1) begin
      obs_code.push_back(int'(event_code));
      obs_cyc.push_back(cyc_n);
    end
    model_edge();
    @(posedge clk);
    #1;
    cyc_n = cyc_n + 1;
    if (overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
  endtask

  function automatic int count_code(int c);
    int n = 0;
    foreach (obs_code[i]) if (obs_code[i] == c) n++;
    return n;
  endfunction

  task automatic clear_obs();
    obs_code.delete();
    obs_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; event_ready = 1'b0;
    buttons = '0; buttons[1] = 1'b1;
    repeat (3) cyc();
    checks++;
    if (event_valid !== 1'b0 || event_code !== 5'd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b c=%0d o=%b, exp v=0 c=0 o=0",
               event_valid, event_code, overrun);
    end
    rst = 1'b0; event_ready = 1'b1; clear_obs();
    for (int i = 0; i < 9; i++) begin
      if (i == 6) buttons = '0;
      cyc();
      checks++;
      if (event_valid !== m_valid || overrun !== m_over ||
          (m_valid && event_code !== 5'(m_code))) begin
        errors++;
        $display("FAIL reset_model cyc %0d: got v=%b c=%0d o=%b, exp v=%b c=%0d o=%b",
                 cyc_n, event_valid, event_code, overrun, m_valid, m_code, m_over);
      end
    end
    checks++;
    if (count_code(1) != 1 || obs_code.size() != 1) begin
      errors++;
      $display("FAIL held_through_reset: got %0d events (%0d code 1), exp 1",
               obs_code.size(), count_code(1));
    end
  endtask

  task automatic test_single_press();
    int p, first_v;
    clear_obs(); event_ready = 1'b1; first_v = -1;
    p = cyc_n; buttons = '0; buttons[3] = 1'b1;
    for (int i = 0; i < 104; i++) begin
      if (i == 100) buttons = '0;
      cyc();
      if (event_valid === 1'b1 && first_v < 0) first_v = cyc_n;
      checks++;
      if (event_valid !== m_valid || overrun !== m_over ||
          (m_valid && event_code !== 5'(m_code))) begin
        errors++;
        $display("FAIL single_model cyc %0d: got v=%b c=%0d o=%b, exp v=%b c=%0d o=%b",
                 cyc_n, event_valid, event_code, overrun, m_valid, m_code, m_over);
      end
    end
    checks++;
    if (obs_code.size() != 1 || count_code(3) != 1) begin
      errors++;
      $display("FAIL single_count: got %0d events (%0d code 3), exp exactly 1 code 3",
               obs_code.size(), count_code(3));
    end
    checks++;
    if (first_v != p + 2) begin
      errors++;
      $display("FAIL single_latency: valid at cycle %0d, exp %0d", first_v, p + 2);
    end
  endtask

  task automatic test_repeat();
    int p, gap;
    clear_obs(); event_ready = 1'b1;
    p = cyc_n; buttons = '0; buttons[16] = 1'b1;
    repeat (60) begin
      cyc();
      checks++;
      if (event_valid !== m_valid || overrun !== m_over ||
          (m_valid && event_code !== 5'(m_code))) begin
        errors++;
        $display("FAIL repeat_model cyc %0d: got v=%b c=%0d o=%b, exp v=%b c=%0d o=%b",
                 cyc_n, event_valid, event_code, overrun, m_valid, m_code, m_over);
      end
    end
    checks++;
    if (obs_code.size() < 4 || count_code(16) != obs_code.size()) begin
      errors++;
      $display("FAIL repeat_count: got %0d events (%0d code 16), exp >=4 all code 16",
               obs_code.size(), count_code(16));
    end else begin
      checks++;
      if (obs_cyc[0] != p + 2) begin
        errors++;
        $display("FAIL repeat_first: at cycle %0d, exp %0d", obs_cyc[0], p + 2);
      end
      gap = obs_cyc[1] - obs_cyc[0];
      checks++;
      if (gap < (DELAY - 1) * TICK_DIV + 1 || gap > DELAY * TICK_DIV) begin
        errors++;
        $display("FAIL repeat_delay: gap %0d, exp %0d..%0d", gap,
                 (DELAY - 1) * TICK_DIV + 1, DELAY * TICK_DIV);
      end
      for (int i = 2; i < obs_cyc.size(); i++) begin
        checks++;
        if (obs_cyc[i] - obs_cyc[i-1] != RATE * TICK_DIV) begin
          errors++;
          $display("FAIL repeat_rate: gap %0d, exp %0d",
                   obs_cyc[i] - obs_cyc[i-1], RATE * TICK_DIV);
        end
      end
    end
    buttons = '0;
    repeat (3) cyc();
    clear_obs();
    repeat (30) begin
      cyc();
      checks++;
      if (event_valid !== m_valid || overrun !== m_over ||
          (m_valid && event_code !== 5'(m_code))) begin
        errors++;
        $display("FAIL release_model cyc %0d: got v=%b c=%0d o=%b, exp v=%b c=%0d o=%b",
                 cyc_n, event_valid, event_code, overrun, m_valid, m_code, m_over);
      end
    end
    checks++;
    if (obs_code.size() != 0) begin
      errors++;
      $display("FAIL repeat_release: got %0d events after release, exp 0", obs_code.size());
    end
  endtask

  task automatic test_stall();
    bit stall_ok;
    clear_obs(); event_ready = 1'b0; stall_ok = 1;
    buttons = '0; buttons[2] = 1'b1; buttons[5] = 1'b1; buttons[9] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) buttons = '0;
      cyc();
      if (event_valid === 1'b1 && event_code !== 5'd2) stall_ok = 0;
      checks++;
      if (event_valid !== m_valid || overrun !== m_over ||
          (m_valid && event_code !== 5'(m_code))) begin
        errors++;
        $display("FAIL stall_model cyc %0d: got v=%b c=%0d o=%b, exp v=%b c=%0d o=%b",
                 cyc_n, event_valid, event_code, overrun, m_valid, m_code, m_over);
      end
    end
    checks++;
    if (!stall_ok || event_valid !== 1'b1 || event_code !== 5'd2) begin
      errors++;
      $display("FAIL stall_hold: got v=%b c=%0d stable=%0d, exp v=1 c=2 stable=1",
               event_valid, event_code, stall_ok);
    end
    event_ready = 1'b1;
    repeat (6) cyc();
    checks++;
    if (obs_code.size() != 3 || obs_code[0] != 2 || obs_code[1] != 5 || obs_code[2] != 9 ||
        obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[1] + 1) begin
      errors++;
      $display("FAIL back_to_back: got %0d events, exp codes 2,5,9 on consecutive cycles",
               obs_code.size());
    end
  endtask

  task automatic test_wrap();
    event_ready = 1'b1;
    buttons = '0; buttons[5] = 1'b1;
    repeat (2) cyc();
    buttons = '0;
    repeat (4) cyc();
    clear_obs();
    buttons[2] = 1'b1; buttons[7] = 1'b1;
    cyc();
    buttons = '0;
    repeat (5) begin
      cyc();
      checks++;
      if (event_valid !== m_valid || overrun !== m_over ||
          (m_valid && event_code !== 5'(m_code))) begin
        errors++;
        $display("FAIL wrap_model cyc %0d: got v=%b c=%0d o=%b, exp v=%b c=%0d o=%b",
                 cyc_n, event_valid, event_code, overrun, m_valid, m_code, m_over);
      end
    end
    checks++;
    if (obs_code.size() != 2 || obs_code[0] != 7 || obs_code[1] != 2) begin
      errors++;
      $display("FAIL wrap_order: got %0d events first=%0d, exp order 7 then 2",
               obs_code.size(), (obs_code.size() > 0) ? obs_code[0] : -1);
    end
  endtask

  task automatic test_overrun();
    clear_obs(); event_ready = 1'b0; ovr_cnt = 0;
    buttons = '0; buttons[0] = 1'b1;
    repeat (4) cyc();
    buttons[4] = 1'b1; cyc();
    buttons[4] = 1'b0; cyc();
    buttons[4] = 1'b1; cyc();
    buttons[4] = 1'b0;
    repeat (3) begin
      cyc();
      checks++;
      if (event_valid !== m_valid || overrun !== m_over ||
          (m_valid && event_code !== 5'(m_code))) begin
        errors++;
        $display("FAIL overrun_model cyc %0d: got v=%b c=%0d o=%b, exp v=%b c=%0d o=%b",
                 cyc_n, event_valid, event_code, overrun, m_valid, m_code, m_over);
      end
    end
    checks++;
    if (ovr_cnt != 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d pulses, exp 1", ovr_cnt);
    end
    event_ready = 1'b1; buttons = '0;
    repeat (5) cyc();
    checks++;
    if (count_code(4) != 1 || count_code(0) != 1) begin
      errors++;
      $display("FAIL overrun_merge: got %0d code-4 and %0d code-0 events, exp 1 each",
               count_code(4), count_code(0));
    end
  endtask

  task automatic test_flush();
    clear_obs(); event_ready = 1'b1;
    buttons = '0; buttons[17] = 1'b1;
    repeat (5) cyc();
    flush = 1'b1; cyc(); flush = 1'b0;
    checks++;
    if (event_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got v=%b, exp 0", event_valid);
    end
    repeat (30) begin
      cyc();
      checks++;
      if (event_valid !== m_valid || overrun !== m_over ||
          (m_valid && event_code !== 5'(m_code))) begin
        errors++;
        $display("FAIL flush_model cyc %0d: got v=%b c=%0d o=%b, exp v=%b c=%0d o=%b",
                 cyc_n, event_valid, event_code, overrun, m_valid, m_code, m_over);
      end
    end
    checks++;
    if (obs_code.size() != 1 || count_code(17) != 1) begin
      errors++;
      $display("FAIL flush_no_repeat: got %0d events, exp only the press of 17",
               obs_code.size());
    end
    buttons = '0;
    repeat (3) cyc();
    clear_obs();
    buttons[17] = 1'b1;
    repeat (4) cyc();
    buttons = '0;
    repeat (4) cyc();
    checks++;
    if (obs_code.size() != 1 || count_code(17) != 1) begin
      errors++;
      $display("FAIL flush_repress: got %0d events (%0d code 17), exp 1 code 17",
               obs_code.size(), count_code(17));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        if (RMASK[i]) begin
          if ($urandom_range(0, 39) == 0) buttons[i] = ~buttons[i];
        end else if ($urandom_range(0, 15) == 0) begin
          buttons[i] = ~buttons[i];
        end
      end
      event_ready = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 63) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      cyc();
      checks++;
      if (event_valid !== m_valid || overrun !== m_over ||
          (m_valid && event_code !== 5'(m_code))) begin
        errors++;
        $display("FAIL random_model cyc %0d: got v=%b c=%0d o=%b, exp v=%b c=%0d o=%b",
                 cyc_n, event_valid, event_code, overrun, m_valid, m_code, m_over);
      end
    end
    rst = 1'b0; flush = 1'b0; buttons = '0;
    clear_obs();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_repeat();
    test_stall();
    test_wrap();
    test_overrun();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
